// File: rtl/render_write_queue_if.sv
// Bundle of the renderer write-queue signals: the core-side push port, the
// flush handshake, status, and the arbiter-side write port.
// The queue uses the slave view; the agent driving the queue uses master.
interface render_write_queue_if;
  logic        inValid;
  logic [15:0] inAddr;
  logic [31:0] inData;
  logic        inReady;
  logic        flushReq;
  logic        flushDone;
  logic        busy;
  logic        rendererOK;
  logic        rendererEnable;
  logic [15:0] rendererAddr;
  logic [31:0] rendererData;
  logic [15:0] stallCycles;

  modport master (
    output inValid, inAddr, inData, flushReq, rendererOK,
    input  inReady, flushDone, busy, rendererEnable, rendererAddr,
           rendererData, stallCycles
  );

  modport slave (
    input  inValid, inAddr, inData, flushReq, rendererOK,
    output inReady, flushDone, busy, rendererEnable, rendererAddr,
           rendererData, stallCycles
  );
endinterface

// File: rtl/render_write_queue.sv
// Renderer write queue: a circular FIFO of {addr, data} pixel writes between
// the renderer core and the memory arbiter. Back-to-back writes to the same
// address are merged into the tail entry. A flush request stops intake until
// the queue has drained, then pulses flushDone for one cycle.
module render_write_queue #(
  parameter int DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  render_write_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Entry storage; contents are meaningful only between head and tail.
  logic [15:0] addr_mem_r [DEPTH];
  logic [31:0] data_mem_r [DEPTH];

  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [AW-1:0] tail_last_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  state_t        state_r;
  state_t        state_next_s;
  logic          flush_done_r;
  logic          flush_done_next_s;
  logic [15:0]   stall_r;

  logic in_ready_s;
  logic enable_s;
  logic push_s;
  logic pop_s;
  logic merge_s;
  logic alloc_s;

  // Most recently allocated entry, the only merge candidate.
  assign tail_last_s = tail_r - AW'(1);

  // Handshake decode; everything is held off while reset is asserted so the
  // outputs read idle even before the first reset edge has cleared state.
  always_comb begin
    in_ready_s = 1'b0;
    enable_s   = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    merge_s    = 1'b0;
    alloc_s    = 1'b0;
    if (reset) begin
      in_ready_s = 1'b0;
      enable_s   = 1'b0;
    end else begin
      in_ready_s = (count_r < DEPTH_C) && (state_r == RUN);
      enable_s   = (count_r != {CW{1'b0}});
      push_s     = bus.inValid && in_ready_s;
      pop_s      = enable_s && bus.rendererOK;
      // A lone entry that is leaving this cycle cannot absorb the new data.
      merge_s    = push_s && (count_r != {CW{1'b0}}) &&
                   (bus.inAddr == addr_mem_r[tail_last_s]) &&
                   !((count_r == CW'(1)) && pop_s);
      alloc_s    = push_s && !merge_s;
    end
  end

  // Occupancy update: a merging push adds nothing, so with a pop it shrinks.
  always_comb begin
    count_next_s = count_r;
    case ({alloc_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Entry storage write: new entry at tail, or data overwrite of the tail entry.
  always_ff @(posedge clock) begin
    if (alloc_s) begin
      addr_mem_r[tail_r] <= bus.inAddr;
      data_mem_r[tail_r] <= bus.inData;
    end else if (merge_s) begin
      data_mem_r[tail_last_s] <= bus.inData;
    end
  end

  // Head/tail pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (pop_s) begin
        head_r <= head_r + AW'(1);
      end
      if (alloc_s) begin
        tail_r <= tail_r + AW'(1);
      end
      count_r <= count_next_s;
    end
  end

  // Flush FSM next-state: drain until empty, then signal completion once.
  always_comb begin
    state_next_s      = state_r;
    flush_done_next_s = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.flushReq) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = RUN;
        end
      end
      FLUSH: begin
        if (count_r == {CW{1'b0}}) begin
          state_next_s      = RUN;
          flush_done_next_s = 1'b1;
        end else begin
          state_next_s = FLUSH;
        end
      end
      default: begin
        state_next_s      = RUN;
        flush_done_next_s = 1'b0;
      end
    endcase
  end

  // Flush FSM state register and registered completion pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= RUN;
      flush_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      flush_done_r <= flush_done_next_s;
    end
  end

  // Saturating count of cycles where the head write was offered but refused.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_r <= 16'd0;
    end else if (enable_s && !bus.rendererOK && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end
  end

  assign bus.inReady        = in_ready_s;
  assign bus.rendererEnable = enable_s;
  assign bus.rendererAddr   = addr_mem_r[head_r];
  assign bus.rendererData   = data_mem_r[head_r];
  assign bus.busy           = !reset && (enable_s || (state_r == FLUSH));
  assign bus.flushDone      = flush_done_r && !reset;
  assign bus.stallCycles    = stall_r;

endmodule

// File: tb/tb_render_write_queue.sv
// Directed bench for render_write_queue (DEPTH = 8): inputs change 1 time
// unit after the rising edge, outputs are sampled 1 unit later.
module tb_render_write_queue;

  logic clock = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  render_write_queue_if bus ();

  render_write_queue #(.DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [31:0] d,
                       input logic ok, input logic fr);
    bus.inValid    = v;
    bus.inAddr     = a;
    bus.inData     = d;
    bus.rendererOK = ok;
    bus.flushReq   = fr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [15:0] q_addr [$];
  logic [31:0] q_data [$];
  logic [15:0] exp_stall;
  logic [15:0] prev_addr;
  logic [15:0] ra;
  logic [31:0] rd;
  logic        rv;
  logic        rok;
  logic        exp_ready;
  logic        nonempty;
  int          pushed;

  initial begin
    // ---------------- reset ----------------
    reset = 1'b1;
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
    #1;
    check("rst0_inReady", bus.inReady, 1'b0);
    check("rst0_enable", bus.rendererEnable, 1'b0);
    step(); step();
    check("rst_inReady", bus.inReady, 1'b0);
    check("rst_enable", bus.rendererEnable, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_flushDone", bus.flushDone, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("post_rst_inReady", bus.inReady, 1'b1);
    check("post_rst_enable", bus.rendererEnable, 1'b0);
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_stall", bus.stallCycles, 16'd0);

    // ---------------- fill with rendererOK low ----------------
    for (int i = 0; i < 8; i++) begin
      step();
      drive(1'b1, 16'(i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
      #1;
      check("fill_inReady", bus.inReady, 1'b1);
      check("fill_stall", bus.stallCycles, (i == 0) ? 16'd0 : 16'(i - 1));
    end
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
    #1;
    check("full_inReady", bus.inReady, 1'b0);
    check("full_enable", bus.rendererEnable, 1'b1);
    check("full_busy", bus.busy, 1'b1);
    check("full_stall", bus.stallCycles, 16'd7);
    step();
    drive(1'b1, 16'h00FF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    #1;
    check("refused_inReady", bus.inReady, 1'b0);
    check("refused_stall", bus.stallCycles, 16'd8);
    for (int j = 0; j < 8; j++) begin
      step();
      drive(1'b0, 16'h0000, 32'h0, 1'b1, 1'b0);
      #1;
      check("drain_enable", bus.rendererEnable, 1'b1);
      check("drain_addr", bus.rendererAddr, 16'(j));
      check("drain_data", bus.rendererData, 32'h1000_0000 + 32'(j));
      check("drain_stall", bus.stallCycles, 16'd9);
    end
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
    #1;
    check("drained_enable", bus.rendererEnable, 1'b0);
    check("drained_busy", bus.busy, 1'b0);
    check("drained_inReady", bus.inReady, 1'b1);
    check("drained_stall", bus.stallCycles, 16'd9);

    // ---------------- merge into single entry ----------------
    step();
    drive(1'b1, 16'h0010, 32'hAAAA_0000, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0010, 32'hBBBB_0000, 1'b0, 1'b0);
    #1;
    check("merge_inReady", bus.inReady, 1'b1);
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b1, 1'b0);
    #1;
    check("merge_enable", bus.rendererEnable, 1'b1);
    check("merge_addr", bus.rendererAddr, 16'h0010);
    check("merge_data", bus.rendererData, 32'hBBBB_0000);
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
    #1;
    check("merge_single", bus.rendererEnable, 1'b0);
    check("merge_stall", bus.stallCycles, 16'd10);

    // ---------------- merge suppressed by concurrent pop ----------------
    step();
    drive(1'b1, 16'h0020, 32'h1234_5678, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0020, 32'h0000_0001, 1'b1, 1'b0);
    #1;
    check("supp_inReady", bus.inReady, 1'b1);
    check("supp_first_addr", bus.rendererAddr, 16'h0020);
    check("supp_first_data", bus.rendererData, 32'h1234_5678);
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b1, 1'b0);
    #1;
    check("supp_second_enable", bus.rendererEnable, 1'b1);
    check("supp_second_addr", bus.rendererAddr, 16'h0020);
    check("supp_second_data", bus.rendererData, 32'h0000_0001);
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
    #1;
    check("supp_empty", bus.rendererEnable, 1'b0);

    // ---------------- merge at count 2 with concurrent pop ----------------
    step();
    drive(1'b1, 16'h0030, 32'h3000_0001, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0031, 32'h3100_0002, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0031, 32'h3100_0003, 1'b1, 1'b0);
    #1;
    check("mpop_head_addr", bus.rendererAddr, 16'h0030);
    check("mpop_head_data", bus.rendererData, 32'h3000_0001);
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b1, 1'b0);
    #1;
    check("mpop_tail_addr", bus.rendererAddr, 16'h0031);
    check("mpop_tail_data", bus.rendererData, 32'h3100_0003);
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
    #1;
    check("mpop_empty", bus.rendererEnable, 1'b0);
    check("mpop_stall", bus.stallCycles, 16'd11);

    // ---------------- flush with 3 entries, rendererOK toggling ----------------
    step();
    drive(1'b1, 16'h0040, 32'h4000_0000, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0041, 32'h4100_0000, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0042, 32'h4200_0000, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b1);
    #1;
    check("flush_req_inReady", bus.inReady, 1'b1);
    check("flush_req_busy", bus.busy, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      drive(1'b1, 16'h00EE, 32'hEEEE_EEEE, (k % 2) == 0, 1'b0);
      #1;
      check("flush_inReady", bus.inReady, 1'b0);
      check("flush_done_early", bus.flushDone, 1'b0);
      check("flush_enable", bus.rendererEnable, 1'b1);
      check("flush_busy", bus.busy, 1'b1);
      check("flush_addr", bus.rendererAddr, 16'h0040 + 16'((k + 1) / 2));
      check("flush_data", bus.rendererData, 32'h4000_0000 + (32'((k + 1) / 2) << 24));
    end
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b1, 1'b0);
    #1;
    check("flush_empty_enable", bus.rendererEnable, 1'b0);
    check("flush_empty_busy", bus.busy, 1'b1);
    check("flush_empty_inReady", bus.inReady, 1'b0);
    check("flush_empty_done", bus.flushDone, 1'b0);
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
    #1;
    check("flush_done_pulse", bus.flushDone, 1'b1);
    check("flush_done_busy", bus.busy, 1'b0);
    check("flush_done_inReady", bus.inReady, 1'b1);
    step();
    check("flush_done_once", bus.flushDone, 1'b0);
    check("flush_stall", bus.stallCycles, 16'd16);

    // ---------------- flush on empty queue ----------------
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b1);
    #1;
    check("eflush_c0_busy", bus.busy, 1'b0);
    check("eflush_c0_done", bus.flushDone, 1'b0);
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
    #1;
    check("eflush_c1_busy", bus.busy, 1'b1);
    check("eflush_c1_inReady", bus.inReady, 1'b0);
    check("eflush_c1_done", bus.flushDone, 1'b0);
    step();
    check("eflush_c2_done", bus.flushDone, 1'b1);
    check("eflush_c2_busy", bus.busy, 1'b0);
    step();
    check("eflush_c3_done", bus.flushDone, 1'b0);

    // ---------------- random traffic across pointer wrap ----------------
    exp_stall = 16'd16;
    prev_addr = 16'h0100;
    pushed    = 0;
    for (int cyc = 0; cyc < 400 && (pushed < 20 || q_addr.size() != 0); cyc++) begin
      step();
      rv  = (pushed < 20);
      ra  = prev_addr + 16'($urandom_range(1, 200));
      rd  = $urandom;
      rok = 1'($urandom_range(0, 1));
      drive(rv, ra, rd, rok, 1'b0);
      #1;
      nonempty  = (q_addr.size() != 0);
      exp_ready = (q_addr.size() < 8);
      check("rnd_inReady", bus.inReady, exp_ready);
      check("rnd_enable", bus.rendererEnable, nonempty);
      if (nonempty && rok) begin
        check("rnd_addr", bus.rendererAddr, q_addr[0]);
        check("rnd_data", bus.rendererData, q_data[0]);
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (nonempty && !rok && exp_stall != 16'hFFFF) begin
        exp_stall = exp_stall + 16'd1;
      end
      if (rv && exp_ready) begin
        q_addr.push_back(ra);
        q_data.push_back(rd);
        prev_addr = ra;
        pushed++;
      end
    end
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
    #1;
    check("rnd_completed", (pushed == 20) && (q_addr.size() == 0), 1'b1);
    check("rnd_final_enable", bus.rendererEnable, 1'b0);
    check("rnd_stall", bus.stallCycles, exp_stall);

    // ---------------- reset mid-flush with 5 entries ----------------
    for (int i = 0; i < 5; i++) begin
      step();
      drive(1'b1, 16'h0050 + 16'(i), 32'h5000_0000 + 32'(i), 1'b0, 1'b0);
    end
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b1);
    #1;
    check("rflush_req_busy", bus.busy, 1'b1);
    step();
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
    #1;
    check("rflush_in_flush_inReady", bus.inReady, 1'b0);
    check("rflush_in_flush_enable", bus.rendererEnable, 1'b1);
    step();
    reset = 1'b1;
    #1;
    check("rflush_rst_enable", bus.rendererEnable, 1'b0);
    check("rflush_rst_busy", bus.busy, 1'b0);
    check("rflush_rst_inReady", bus.inReady, 1'b0);
    check("rflush_rst_done", bus.flushDone, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("rflush_post_enable", bus.rendererEnable, 1'b0);
    check("rflush_post_busy", bus.busy, 1'b0);
    check("rflush_post_stall", bus.stallCycles, 16'd0);
    check("rflush_post_done", bus.flushDone, 1'b0);
    check("rflush_post_inReady", bus.inReady, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rflush_no_done", bus.flushDone, 1'b0);
      check("rflush_no_enable", bus.rendererEnable, 1'b0);
    end

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/render_write_queue.md
RENDER_WRITE_QUEUE -- requirements
Module: render_write_queue

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clock.
REQ-002 Parameter: DEPTH, 8, number of queue entries (power of two, 2..32).
REQ-003 Ports (name  direction  width  meaning):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- inValid  in  1  renderer core offers a pixel write
- inAddr  in  16  word address of the write
- inData  in  32  write data
- inReady  out  1  queue accepts the offered write this cycle
- flushReq  in  1  request to drain all queued writes
- flushDone  out  1  one-cycle pulse when a flush completes
- busy  out  1  queue non-empty or flush in progress
- rendererOK  in  1  arbiter grants the renderer slot this cycle (combinational)
- rendererEnable  out  1  head entry presented for write
- rendererAddr  out  16  head entry address
- rendererData  out  32  head entry data
- stallCycles  out  16  saturating count of refused write cycles

Function
REQ-004 Storage SHALL be a circular FIFO of DEPTH entries {addr16, data32} with head pointer, tail pointer and count (0..DEPTH).
REQ-005 Push SHALL occur when inValid && inReady.
REQ-006 inReady SHALL equal (count < DEPTH) && (state == RUN), with no dependence on rendererOK or pop.
REQ-007 rendererEnable SHALL equal (count != 0); rendererAddr/rendererData SHALL show the head entry combinationally and are don't-care when count == 0.
REQ-008 Pop SHALL occur when rendererEnable && rendererOK; the head advances by one, modulo DEPTH.
REQ-009 The head entry SHALL stay stable while rendererOK is low; no entry is dropped or reordered.
REQ-010 Merge: on a push with count >= 1 and inAddr equal to the tail entry address, inData SHALL overwrite the tail entry data; no new entry is allocated.
REQ-011 Merge SHALL be suppressed when count == 1 and a pop occurs in the same cycle; the push then allocates a new entry.
REQ-012 Simultaneous push and pop SHALL leave count unchanged, except for a merging push, which decrements count by one.
REQ-013 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-014 FSM states: RUN and FLUSH.
- RUN: a flushReq moves the FSM to FLUSH on the next cycle.
- RUN: a push in the same cycle as flushReq is accepted.
- FLUSH: inReady = 0 and flushReq is ignored.
- FLUSH: when count == 0 at a clock edge, the next state is RUN and flushDone = 1 for exactly that following cycle.
REQ-015 flushReq with an empty queue SHALL produce FLUSH for one cycle, then flushDone in the next cycle (2-cycle latency).
REQ-016 busy SHALL equal (count != 0) || (state == FLUSH).
REQ-017 stallCycles SHALL increment on every cycle with rendererEnable && !rendererOK and saturate at 0xFFFF.

Reset
REQ-018 While reset is high, the block SHALL set count = 0, head = tail = 0, state = RUN and stallCycles = 0.
REQ-019 While reset is high, the outputs SHALL be: flushDone = 0, rendererEnable = 0, busy = 0, inReady = 0.
REQ-020 In the first cycle after reset deasserts, the outputs SHALL be: inReady = 1, rendererEnable = 0, busy = 0.
REQ-021 Reset mid-operation SHALL discard all queued entries with no further rendererEnable and SHALL abort a pending flush with no flushDone.
REQ-022 Storage array contents need not be reset.

Verification
REQ-023 Fill with rendererOK = 0: push addresses 0x0000..0x0007 (DEPTH = 8) -> inReady = 0 after the 8th push and stallCycles counts every cycle. Then set rendererOK = 1 -> 8 writes are issued in order, one per cycle, and count returns to 0.
REQ-024 Merge: push (0x0010, 0xAAAA0000) then (0x0010, 0xBBBB0000) with rendererOK = 0 -> count = 1. Release rendererOK -> a single write of 0xBBBB0000 to 0x0010 is issued.
REQ-025 Merge suppression: count = 1 with head at 0x0020, rendererOK = 1, push (0x0020, 0x1) in the same cycle -> two writes to 0x0020 are issued, the original data first and then 0x1.
REQ-026 Flush: 3 entries queued, flushReq pulse, rendererOK toggling 1/0 each cycle -> inReady = 0 throughout FLUSH, 3 writes are issued, and flushDone pulses exactly once in the cycle after count reaches 0. A flushReq on an empty queue -> flushDone 2 cycles later.
REQ-027 Wrap and concurrency: 20 random writes pushed while rendererOK is randomly high 50% of the time, no repeated adjacent addresses -> the issued sequence matches the pushed sequence exactly across the pointer wrap.
REQ-028 Reset mid-flush with 5 entries queued -> the next cycle shows rendererEnable = 0, busy = 0, stallCycles = 0, and no flushDone pulse.
